fifo_wptr_full: RTL and testbench

//  Write-side control for the async FIFO, running entirely in the wclk domain.

---
 rtl/fifo_wptr_full.sv | 71 +++++++
 tb/tb_fifo_wptr_full.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and flag logic for the async FIFO, entirely in the wclk domain.
// Produces the RAM write port, the Gray write pointer and the full/almost-full/count/overflow status.
module fifo_wptr_full #(
    parameter int ADDRSIZE = 5,
    parameter int AF_LEVEL = 28
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   rptr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic                wclken,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wcount,
    output logic                woverflow
);

    localparam logic [ADDRSIZE:0] AF_THRESH = (ADDRSIZE + 1)'(AF_LEVEL);

    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] wq1_rptr;
    logic [ADDRSIZE:0] wq2_rptr;
    logic [ADDRSIZE:0] wbin_next;
    logic [ADDRSIZE:0] wgray_next;
    logic [ADDRSIZE:0] rbin_sync;
    logic [ADDRSIZE:0] fill_next;
    logic              wfull_next;

    assign waddr  = wbin[ADDRSIZE-1:0];
    assign wclken = winc & ~wfull;

    always_comb begin
        rbin_sync = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            rbin_sync[i] = ^(wq2_rptr >> i);
        end
    end

    always_comb begin
        wbin_next  = wbin + {{ADDRSIZE{1'b0}}, wclken};
        wgray_next = (wbin_next >> 1) ^ wbin_next;
        fill_next  = wbin_next - rbin_sync;
        // Full when the write pointer is one lap ahead of the synchronised read pointer.
        wfull_next = (wgray_next == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin         <= '0;
            wptr         <= '0;
            wq1_rptr     <= '0;
            wq2_rptr     <= '0;
            wcount       <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            woverflow    <= 1'b0;
        end else begin
            wq1_rptr     <= rptr;
            wq2_rptr     <= wq1_rptr;
            wbin         <= wbin_next;
            wptr         <= wgray_next;
            wcount       <= fill_next;
            wfull        <= wfull_next;
            walmost_full <= (fill_next >= AF_THRESH);
            woverflow    <= woverflow | (winc & wfull);
        end
    end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Scoreboard bench for fifo_wptr_full: the driver queues expectations, a negedge monitor checks them.
module tb_fifo_wptr_full;

    logic       wclk;
    logic       wrst;
    logic       winc;
    logic [5:0] rptr;
    logic [4:0] waddr;
    logic       wclken;
    logic [5:0] wptr;
    logic       wfull;
    logic       walmost_full;
    logic [5:0] wcount;
    logic       woverflow;

    fifo_wptr_full #(.ADDRSIZE(5), .AF_LEVEL(28)) dut (
        .wclk(wclk), .wrst(wrst), .winc(winc), .rptr(rptr),
        .waddr(waddr), .wclken(wclken), .wptr(wptr), .wfull(wfull),
        .walmost_full(walmost_full), .wcount(wcount), .woverflow(woverflow)
    );

    typedef struct {
        int         cyc;
        bit         kind;
        string      name;
        logic [4:0] waddr;
        logic [5:0] wptr;
        logic [5:0] wcount;
        logic       wfull;
        logic       waf;
        logic       wovf;
        logic       wclken;
    } exp_t;

    exp_t q[$];
    exp_t m;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    always @(posedge wclk) cyc <= cyc + 1;

    function automatic logic [5:0] g(input int x);
        logic [5:0] b;
        b = x[5:0];
        return b ^ (b >> 1);
    endfunction

    task automatic cmp(input string nm, input string fld, input logic [5:0] act, input logic [5:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s %s: got %0h expected %0h (cycle %0d)", nm, fld, act, req, cyc);
        end
    endtask

    always @(negedge wclk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            m = q.pop_front();
            if (m.cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL %s stale: got cycle %0d expected cycle %0d", m.name, cyc, m.cyc);
            end else if (m.kind) begin
                cmp(m.name, "wclken", {5'b0, wclken}, {5'b0, m.wclken});
            end else begin
                cmp(m.name, "waddr", {1'b0, waddr}, {1'b0, m.waddr});
                cmp(m.name, "wptr", wptr, m.wptr);
                cmp(m.name, "wcount", wcount, m.wcount);
                cmp(m.name, "wfull", {5'b0, wfull}, {5'b0, m.wfull});
                cmp(m.name, "walmost_full", {5'b0, walmost_full}, {5'b0, m.waf});
                cmp(m.name, "woverflow", {5'b0, woverflow}, {5'b0, m.wovf});
            end
        end
    end

    task automatic step(input logic inc, input logic [5:0] rp, input logic rst, input string nm,
                        input logic [4:0] ea, input logic [5:0] ep, input logic [5:0] ec,
                        input logic ef, input logic eaf, input logic eov, input logic ewc);
        exp_t e;
        winc = inc;
        rptr = rp;
        wrst = rst;
        e.cyc = cyc; e.kind = 1'b1; e.name = nm;
        e.waddr = '0; e.wptr = '0; e.wcount = '0;
        e.wfull = 1'b0; e.waf = 1'b0; e.wovf = 1'b0; e.wclken = ewc;
        q.push_back(e);
        e.cyc = cyc + 1; e.kind = 1'b0;
        e.waddr = ea; e.wptr = ep; e.wcount = ec;
        e.wfull = ef; e.waf = eaf; e.wovf = eov;
        q.push_back(e);
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset(input string nm);
        step(1'b0, 6'd0, 1'b1, nm, 5'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        wrst = 1'b1;
        winc = 1'b0;
        rptr = 6'd0;
        repeat (2) @(posedge wclk);
        #1;

        // 1: reset then three writes
        do_reset("t1_reset");
        for (int i = 1; i <= 3; i++)
            step(1'b1, 6'd0, 1'b0, "t1_write", 5'(i), g(i), 6'(i), 1'b0, 1'b0, 1'b0, 1'b1);

        // 2: fill to full
        do_reset("t2_reset");
        for (int i = 1; i <= 32; i++)
            step(1'b1, 6'd0, 1'b0, "t2_fill", 5'(i % 32), g(i), 6'(i),
                 (i == 32), (i >= 28), 1'b0, 1'b1);

        // 3: write while full sets sticky overflow
        step(1'b1, 6'd0, 1'b0, "t3_overflow", 5'd0, 6'b110000, 6'd32, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 6'd0, 1'b0, "t3_sticky", 5'd0, 6'b110000, 6'd32, 1'b1, 1'b1, 1'b1, 1'b0);

        // 4: one read frees a slot after the synchroniser delay
        step(1'b0, 6'b000001, 1'b0, "t4_edge1", 5'd0, 6'b110000, 6'd32, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 6'b000001, 1'b0, "t4_edge2", 5'd0, 6'b110000, 6'd32, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 6'b000001, 1'b0, "t4_release", 5'd0, 6'b110000, 6'd31, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 6'b000001, 1'b0, "t4_accept", 5'd1, 6'b110001, 6'd32, 1'b1, 1'b1, 1'b1, 1'b1);

        // 6: reset mid-stream discards the write in the reset cycle
        do_reset("t6_reset");
        for (int i = 1; i <= 20; i++)
            step(1'b1, 6'd0, 1'b0, "t6_write", 5'(i), g(i), 6'(i), 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 6'd0, 1'b1, "t6_rst_winc", 5'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 6'd0, 1'b0, "t6_after", 5'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // 5: stream with a lagging read pointer, waddr wraps repeatedly
        do_reset("t5_reset");
        for (int k = 1; k <= 100; k++) begin
            int rd;
            int lag;
            rd  = (k > 3) ? k - 3 : 0;
            lag = (k > 5) ? k - 5 : 0;
            step(1'b1, g(rd), 1'b0, "t5_stream", 5'(k % 32), g(k % 64), 6'(k - lag),
                 1'b0, 1'b0, 1'b0, 1'b1);
        end

        winc = 1'b0;
        repeat (3) @(posedge wclk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
